// File: rtl/go_sequencer.sv
// go_sequencer: in-order go/kill/done initiator for a chain of NUM_STAGES stages, with a per-stage watchdog.
// Latency: start -> go_out[0] next cycle; done_in[i] -> go_out[i+1] next cycle; stall -> kill TIMEOUT+1 cycles after go.
// Backpressure: none; start is ignored while busy, and only done_in[idx] of the active stage is observed.
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   start, abort, err_clr    sequence launch, user abort, clear of the sticky timeout flag
//   done_in[NUM_STAGES]      per-stage done pulses
//   go_out, kill_out         one-cycle per-stage go / kill pulses
//   busy, seq_done           sequence in flight / one-cycle completion pulse
//   timeout_err, err_stage   sticky timeout flag and index of the last stage that timed out
module go_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int TIMEOUT    = 16,
  parameter int STAGE_W    = 2,
  parameter int TMR_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  err_clr,
  input  logic [NUM_STAGES-1:0] done_in,
  output logic [NUM_STAGES-1:0] go_out,
  output logic [NUM_STAGES-1:0] kill_out,
  output logic                  busy,
  output logic                  seq_done,
  output logic                  timeout_err,
  output logic [STAGE_W-1:0]    err_stage
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GO     = 3'd1,
    S_WAIT   = 3'd2,
    S_KILL   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [STAGE_W-1:0] LAST_IDX = STAGE_W'(NUM_STAGES - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t             state;
  state_t             state_nxt;
  logic [STAGE_W-1:0] idx;
  logic [STAGE_W-1:0] idx_nxt;
  logic [TMR_W-1:0]   tmr;
  logic [TMR_W-1:0]   tmr_nxt;
  logic               err_set;    // watchdog fired this cycle
  logic               seq_launch; // start accepted this cycle

  // State register plus the datapath registers that ride along with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      tmr         <= '0;
      timeout_err <= 1'b0;
      err_stage   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      tmr   <= tmr_nxt;
      // A timeout in the same cycle as a clear keeps the flag set.
      if (err_set) begin
        timeout_err <= 1'b1;
        err_stage   <= idx;
      end else if (seq_launch || err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

  // Next-state logic. In WAIT: abort beats done, done beats the watchdog,
  // so a done arriving on the final watchdog cycle is still accepted.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    tmr_nxt    = tmr;
    err_set    = 1'b0;
    seq_launch = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_GO;
          idx_nxt    = '0;
          seq_launch = 1'b1;
        end
      end
      S_GO: begin
        tmr_nxt   = '0;
        state_nxt = abort ? S_KILL : S_WAIT;
      end
      S_WAIT: begin
        if (abort) begin
          state_nxt = S_KILL;
        end else if (done_in[idx]) begin
          if (idx == LAST_IDX) begin
            state_nxt = S_FINISH;
          end else begin
            state_nxt = S_GO;
            idx_nxt   = idx + STAGE_W'(1);
          end
        end else if (tmr == TMR_LAST) begin
          state_nxt = S_KILL;
          err_set   = 1'b1;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      S_KILL:   state_nxt = S_IDLE;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Moore output decode of the registered state and stage index.
  always_comb begin
    go_out   = '0;
    kill_out = '0;
    busy     = (state != S_IDLE);
    seq_done = (state == S_FINISH);
    if (state == S_GO)   go_out[idx]   = 1'b1;
    if (state == S_KILL) kill_out[idx] = 1'b1;
  end

endmodule
